uart_tx: RTL and testbench

//   Serial UART transmitter: drives the TX line toward the simulation console and NVBoard UART, the

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and the default baud divisor, so that a future
// receiver can run at the same bit rate.
package uart_tx_pkg;

  // Default clk cycles per serial bit.
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick on the last count.
// The counter is held at zero whenever en is low, so each frame starts on a clean bit boundary.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == CntMax);

  // Next count: wrap on tick, clear while disabled.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || bit_tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts bytes over valid/ready into a one-entry holding register and shifts
// them out LSB first as start / data / optional even parity / stop frames. A byte waiting in the
// holding register is started directly from the last stop bit, giving back-to-back frames.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  // Wide enough for both the data bit index (<= 7) and the stop bit index (<= 1).
  localparam int unsigned IdxW = 3;
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 txd_q, txd_d;

  logic bit_tick;
  logic accept;
  logic unload;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != StIdle),
    .bit_tick(bit_tick)
  );

  // tx_ready comes straight from the hold flag, so it never depends on tx_valid.
  assign tx_ready = !hold_full_q;
  assign accept   = tx_valid && tx_ready;
  assign txd      = txd_q;
  assign busy     = (state_q != StIdle) || hold_full_q;

  // Frame sequencing, shift register and parity capture; txd is pre-computed from the next state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    idx_d   = idx_q;
    unload  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          state_d = StStart;
          unload  = 1'b1;
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (idx_q == LastStop) begin
            idx_d = '0;
            // A waiting byte goes straight into its start bit: no idle gap.
            if (hold_full_q) begin
              state_d = StStart;
              unload  = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (unload) begin
      shift_d = hold_q;
      par_d   = ^hold_q;
    end

    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  // Holding register: a fill takes priority over the unload that empties it.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else if (unload) begin
      hold_full_d = 1'b0;
    end
  end

  // State registers; reset aborts any frame and drops a held byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      txd_q       <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (default 8N1 @16, 8E1 @4, 8N2 @2) checked every cycle
// against a frame-level line model, plus directed scenarios and a line decoder on the 8N2 port.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst   = 3'b111;
  logic [2:0] valid = 3'b000;
  logic [7:0] data [3];
  wire  [2:0] ready;
  wire  [2:0] txd;
  wire  [2:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(ready[0]), .txd(txd[0]), .busy(busy[0])
  );
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(ready[1]), .txd(txd[1]), .busy(busy[1])
  );
  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .tx_valid(valid[2]), .tx_data(data[2]),
    .tx_ready(ready[2]), .txd(txd[2]), .busy(busy[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cpb_of(input int i);
    case (i)
      0:       return 16;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic bit par_of(input int i);
    return i == 1;
  endfunction

  function automatic int stp_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // Line model: a frame is a bit vector shown for cpb cycles per bit; one byte may wait behind it.
  bit          m_act  [3];
  bit          m_full [3];
  logic [7:0]  m_hold [3];
  logic [15:0] m_vec  [3];
  int          m_len  [3];
  int          m_el   [3];
  logic [7:0]  sent2_q[$];

  int cyc = 0;
  bit chk_en = 1'b0;
  bit sticky [3];

  task automatic model_step(input int i);
    bit   hb;
    logic [7:0] d;
    int   n;
    if (rst[i]) begin
      m_act[i]  = 1'b0;
      m_full[i] = 1'b0;
      return;
    end
    hb = m_full[i];
    if (m_act[i]) begin
      m_el[i]++;
      if (m_el[i] == m_len[i] * cpb_of(i)) m_act[i] = 1'b0;
    end
    if (!m_act[i] && hb) begin
      d = m_hold[i];
      m_vec[i] = '1;
      m_vec[i][0] = 1'b0;
      for (int k = 0; k < 8; k++) m_vec[i][1+k] = d[k];
      n = 9;
      if (par_of(i)) begin
        m_vec[i][9] = ^d;
        n = 10;
      end
      m_len[i]  = n + stp_of(i);
      m_el[i]   = 0;
      m_act[i]  = 1'b1;
      m_full[i] = 1'b0;
    end
    if (valid[i] && !hb) begin
      m_full[i] = 1'b1;
      m_hold[i] = data[i];
      if (i == 2) sent2_q.push_back(data[i]);
    end
  endtask

  function automatic logic exp_txd(input int i);
    if (!m_act[i]) return 1'b1;
    return m_vec[i][m_el[i] / cpb_of(i)];
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) model_step(i);
  end

  // Per-cycle comparison against the model; stops reporting a port after its first divergence.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        if (!sticky[i]) begin
          if (txd[i] !== exp_txd(i) || ready[i] !== !m_full[i] ||
              busy[i] !== (m_act[i] | m_full[i])) sticky[i] = 1'b1;
          check_eq($sformatf("model_txd%0d", i), txd[i], exp_txd(i));
          check_eq($sformatf("model_ready%0d", i), ready[i], !m_full[i]);
          check_eq($sformatf("model_busy%0d", i), busy[i], m_act[i] | m_full[i]);
        end
      end
    end
  end

  // Receiver model on the 8N2, 2-cycle port: bit k occupies counts 2k..2k+1 after start detect.
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  int         rx_ferr = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  int         rx_start[$];

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rx_on) begin
        if (txd[2] === 1'b0) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
          rx_start.push_back(cyc);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == 1 && txd[2] !== 1'b0) rx_ferr++;
        if (rx_cnt % 2 == 1 && rx_cnt >= 3 && rx_cnt <= 17) rx_sh[(rx_cnt-3)/2] = txd[2];
        if ((rx_cnt == 19 || rx_cnt == 21) && txd[2] !== 1'b1) rx_ferr++;
        if (rx_cnt == 21) begin
          rx_q.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("idle_reached%0d", i), busy[i], 1'b0);
  endtask

  // Caller is at a negedge with the holding register empty.
  task automatic send_one(input int i, input logic [7:0] b, output int t_acc);
    check_eq("ready_before_send", ready[i], 1'b1);
    valid[i] = 1'b1;
    data[i]  = b;
    @(negedge clk);
    t_acc    = cyc;
    valid[i] = 1'b0;
  endtask

  // Keeps tx_valid high across both bytes; the second waits for the first to leave the hold.
  task automatic send_pair(input int i, input logic [7:0] a, input logic [7:0] b,
                           output int t_acc);
    int n = 0;
    check_eq("ready_before_pair", ready[i], 1'b1);
    valid[i] = 1'b1;
    data[i]  = a;
    @(negedge clk);
    t_acc   = cyc;
    check_eq("pair_ready_full", ready[i], 1'b0);
    data[i] = b;
    while (ready[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("pair_ready_back", ready[i], 1'b1);
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  task automatic t4_parity(input logic [7:0] b, input logic p);
    int t;
    send_one(1, b, t);
    wait_until(t + 1 + 9 * 4 + 1);
    check_eq("t4_parity_bit", txd[1], p);
    wait_until(t + 1 + 10 * 4 + 1);
    check_eq("t4_stop_bit", txd[1], 1'b1);
    wait_until(t + 44);
    check_eq("t4_busy_last", busy[1], 1'b1);
    wait_until(t + 45);
    check_eq("t4_busy_end", busy[1], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, errs, lows;
    logic exp_bits [10];
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) data[i] = 8'h00;

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst    = 3'b000;

    // Reset state held through 100 idle cycles.
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_txd", txd[i], 1'b1);
      check_eq("reset_ready", ready[i], 1'b1);
      check_eq("reset_busy", busy[i], 1'b0);
    end
    errs = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (txd !== 3'b111 || ready !== 3'b111 || busy !== 3'b000) errs++;
    end
    check_eq("idle_100_cycles", errs, 0);

    // 0xA5 on the default port, checked bit by bit.
    send_one(0, 8'hA5, t);
    check_eq("t2_pre_start", txd[0], 1'b1);
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int c = 0; c < 16; c++) begin
        wait_until(t + 1 + 16 * b + c);
        if (txd[0] !== exp_bits[b]) errs++;
      end
      check_eq($sformatf("t2_bit%0d_bad_cycles", b), errs, 0);
    end
    check_eq("t2_busy_in_stop", busy[0], 1'b1);
    wait_until(t + 161);
    check_eq("t2_busy_end", busy[0], 1'b0);

    // Back-to-back with the second byte queued.
    send_pair(0, 8'h01, 8'h02, t);
    wait_until(t + 160);
    check_eq("t3_last_stop", txd[0], 1'b1);
    wait_until(t + 161);
    check_eq("t3_back2back_start", txd[0], 1'b0);
    wait_idle(0);

    // Even parity.
    t4_parity(8'h07, 1'b1);
    t4_parity(8'h03, 1'b0);

    // Reset in the middle of data bit 3 with a second byte held.
    send_pair(0, 8'h3C, 8'hC3, t);
    check_eq("t5_hold_full", ready[0], 1'b0);
    wait_until(t + 1 + 4 * 16 + 8);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check_eq("t5_txd", txd[0], 1'b1);
    check_eq("t5_ready", ready[0], 1'b1);
    check_eq("t5_busy", busy[0], 1'b0);
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
    end
    check_eq("t5_no_low_after_reset", lows, 0);

    // Two stop bits at 2 cycles per bit.
    send_pair(2, 8'hFF, 8'h00, t);
    wait_until(t + 44);
    check_eq("t6_busy_last", busy[2], 1'b1);
    wait_until(t + 45);
    check_eq("t6_busy_end", busy[2], 1'b0);
    check_eq("t6_frames_seen", rx_start.size(), 2);
    if (rx_start.size() >= 2) begin
      check_eq("t6_first_start", rx_start[0], t + 1);
      check_eq("t6_frame_len", rx_start[1] - rx_start[0], 22);
      check_eq("t6_byte0", rx_q[0], 8'hFF);
      check_eq("t6_byte1", rx_q[1], 8'h00);
    end

    // Random traffic on all ports.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        data[i]  = 8'($urandom);
      end
      @(negedge clk);
    end
    valid = 3'b000;
    for (int i = 0; i < 3; i++) wait_idle(i);
    @(negedge clk);
    check_eq("rx_count", rx_q.size(), sent2_q.size());
    errs = 0;
    for (int k = 0; k < rx_q.size() && k < sent2_q.size(); k++) begin
      if (rx_q[k] !== sent2_q[k]) errs++;
    end
    check_eq("rx_byte_errors", errs, 0);
    check_eq("rx_frame_errors", rx_ferr, 0);
    errs = 0;
    for (int k = 1; k < rx_start.size(); k++) begin
      if (rx_start[k] - rx_start[k-1] < 22) errs++;
    end
    check_eq("rx_short_frames", errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
